// File: rtl/jstk_pkg.sv
// ---------------------------------------------------------------------------
// jstk_pkg
// Shared definitions for the PmodJSTK joystick SPI link. Both the joystick
// master and the responder model import this package so that frame length,
// LED-command encoding and the transmit byte layout stay in one place.
//
// Contents:
//   JSTK_NBYTES / JSTK_FRAME_BITS   frame length in bytes / bits
//   JSTK_CMD_LED_HI                 upper six bits of an LED command byte
//   JSTK_BYTE_*                     byte positions in the responder tx frame
//   jstk_state_e                    responder FSM state encoding
//   jstk_tx_byte / jstk_tx_frame    build the responder tx frame
// ---------------------------------------------------------------------------
package jstk_pkg;

    localparam int JSTK_NBYTES     = 5;
    localparam int JSTK_FRAME_BITS = 40;

    localparam logic [5:0] JSTK_CMD_LED_HI = 6'b100000;

    // Byte 0 leaves the responder first.
    localparam int JSTK_BYTE_X_LO = 0;
    localparam int JSTK_BYTE_X_HI = 1;
    localparam int JSTK_BYTE_Y_LO = 2;
    localparam int JSTK_BYTE_Y_HI = 3;
    localparam int JSTK_BYTE_BTN  = 4;

    typedef enum logic [1:0] {
        ST_WAIT_HI = 2'd0,
        ST_IDLE    = 2'd1,
        ST_SHIFT   = 2'd2,
        ST_DONE    = 2'd3
    } jstk_state_e;

    function automatic logic [7:0] jstk_tx_byte(
        input logic [9:0] x,
        input logic [9:0] y,
        input logic [2:0] btn,
        input int         idx
    );
        logic [7:0] b;
        case (idx)
            JSTK_BYTE_X_LO: b = x[7:0];
            JSTK_BYTE_X_HI: b = {6'b0, x[9:8]};
            JSTK_BYTE_Y_LO: b = y[7:0];
            JSTK_BYTE_Y_HI: b = {6'b0, y[9:8]};
            JSTK_BYTE_BTN:  b = {5'b0, btn};
            default:        b = 8'h00;
        endcase
        return b;
    endfunction

    // Byte 0 lands in the top byte so the frame shifts out MSB first.
    function automatic logic [JSTK_FRAME_BITS-1:0] jstk_tx_frame(
        input logic [9:0] x,
        input logic [9:0] y,
        input logic [2:0] btn
    );
        logic [JSTK_FRAME_BITS-1:0] f;
        f = '0;
        for (int i = 0; i < JSTK_NBYTES; i++) begin
            f[JSTK_FRAME_BITS-1-8*i -: 8] = jstk_tx_byte(x, y, btn, i);
        end
        return f;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// ---------------------------------------------------------------------------
// sync_edge
// Multi-flop synchroniser for an asynchronous input with edge detection on
// the synchronised copy.
//
// Ports:
//   clk    in   system clock
//   clr_n  in   asynchronous active-low reset
//   din    in   asynchronous input
//   level  out  synchronised level (SYNC_STAGES clk behind din)
//   rise   out  1-clk pulse on a 0->1 change of level
//   fall   out  1-clk pulse on a 1->0 change of level
// ---------------------------------------------------------------------------
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic clr_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            chain_q <= '0;
            prev_q  <= 1'b0;
        end else begin
            chain_q <= {chain_q[SYNC_STAGES-2:0], din};
            prev_q  <= chain_q[SYNC_STAGES-1];
        end
    end

    assign level = chain_q[SYNC_STAGES-1];
    assign rise  =  level & ~prev_q;
    assign fall  = ~level &  prev_q;

endmodule

// File: rtl/jstk_spi_responder.sv
// ---------------------------------------------------------------------------
// jstk_spi_responder
// SPI-slave model of the PmodJSTK joystick. Answers 5-byte mode-0 frames with
// X/Y position and button bytes, and captures the master's LED command.
// All SPI inputs are oversampled in the clk domain (f(SCLK) <= f(clk)/8).
//
// Ports:
//   clk         in   system clock, sole clock domain
//   clr_n       in   asynchronous active-low reset
//   SCLK        in   SPI clock, CPOL=0 CPHA=0, MSB first
//   SS          in   active-low slave select
//   MOSI        in   master-out data
//   MISO        out  slave-out data
//   x_pos       in   X position to report
//   y_pos       in   Y position to report
//   buttons     in   {btn2,btn1,trigger}
//   led_cmd     out  {led2,led1} from the last valid LED command
//   frame_done  out  1-clk pulse, well-formed 40-bit frame completed
//   frame_err   out  1-clk pulse, frame ended with bit count != 40
//
// state    | meaning
// ---------+------------------------------------------------------------
// WAIT_HI  | after reset; ignore any frame in progress until SS is high
// IDLE     | SS high, MISO low; SS fall snapshots inputs into tx shifter
// SHIFT    | SCLK rise samples MOSI, SCLK fall advances MISO
// DONE     | one cycle; judge bit count, pulse done/err, apply LED cmd
// ---------------------------------------------------------------------------
module jstk_spi_responder
    import jstk_pkg::*;
#(
    parameter int NBYTES      = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       SCLK,
    input  logic       SS,
    input  logic       MOSI,
    output logic       MISO,
    input  logic [9:0] x_pos,
    input  logic [9:0] y_pos,
    input  logic [2:0] buttons,
    output logic [1:0] led_cmd,
    output logic       frame_done,
    output logic       frame_err
);

    localparam int         FB         = JSTK_FRAME_BITS;
    localparam logic [5:0] FRAME_BITS = 6'(NBYTES * 8);
    // One past a full frame: enough to tell "exactly 40" from "too many".
    localparam logic [5:0] BITCNT_SAT = FRAME_BITS + 6'd1;

    logic sclk_level, sclk_rise, sclk_fall;
    logic ss_level, ss_rise, ss_fall;
    logic mosi_s;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk   (clk),
        .clr_n (clr_n),
        .din   (SCLK),
        .level (sclk_level),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ss (
        .clk   (clk),
        .clr_n (clr_n),
        .din   (SS),
        .level (ss_level),
        .rise  (ss_rise),
        .fall  (ss_fall)
    );

    // MOSI only needs a level; it is sampled on the synced SCLK rise, so it
    // must see the same pipeline depth as SCLK.
    logic [SYNC_STAGES-1:0] mosi_sync_q;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            mosi_sync_q <= '0;
        end else begin
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
        end
    end

    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    jstk_state_e   state_q, state_d;
    logic [FB-1:0] tx_q, tx_d;
    logic [FB-1:0] rx_q, rx_d;
    logic [5:0]    bitcnt_q, bitcnt_d;
    logic [1:0]    led_q, led_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q  <= ST_WAIT_HI;
            tx_q     <= '0;
            rx_q     <= '0;
            bitcnt_q <= '0;
            led_q    <= 2'b00;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            bitcnt_q <= bitcnt_d;
            led_q    <= led_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        bitcnt_d = bitcnt_q;
        led_d    = led_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            ST_WAIT_HI: begin
                if (ss_level) begin
                    state_d = ST_IDLE;
                end
            end

            ST_IDLE: begin
                if (ss_fall) begin
                    tx_d     = jstk_tx_frame(x_pos, y_pos, buttons);
                    rx_d     = '0;
                    bitcnt_d = '0;
                    state_d  = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                // SS rise takes priority; a coincident SCLK edge is dropped.
                if (ss_rise) begin
                    state_d = ST_DONE;
                end else begin
                    if (sclk_rise) begin
                        if (bitcnt_q < FRAME_BITS) begin
                            rx_d = {rx_q[FB-2:0], mosi_s};
                        end
                        if (bitcnt_q != BITCNT_SAT) begin
                            bitcnt_d = bitcnt_q + 6'd1;
                        end
                    end
                    if (sclk_fall) begin
                        tx_d = {tx_q[FB-2:0], 1'b0};
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                if (bitcnt_q == FRAME_BITS) begin
                    done_d = 1'b1;
                    if (rx_q[FB-1 -: 6] == JSTK_CMD_LED_HI) begin
                        led_d = rx_q[FB-7 -: 2];
                    end
                end else begin
                    err_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_WAIT_HI;
            end
        endcase
    end

    // tx_q is loaded on the SS-fall cycle and shifted on each SCLK fall, so
    // its top bit is the current MISO bit whenever a frame is in SHIFT.
    assign MISO       = (state_q == ST_SHIFT) ? tx_q[FB-1] : 1'b0;
    assign led_cmd    = led_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;

endmodule

// File: tb/tb_jstk_spi_responder.sv
module tb_jstk_spi_responder;

    logic       clk = 1'b0;
    logic       clr_n;
    logic       SCLK;
    logic       SS;
    logic       MOSI;
    logic       MISO;
    logic [9:0] x_pos;
    logic [9:0] y_pos;
    logic [2:0] buttons;
    logic [1:0] led_cmd;
    logic       frame_done;
    logic       frame_err;

    always #5 clk = ~clk;

    jstk_spi_responder #(.NBYTES(5), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .SCLK       (SCLK),
        .SS         (SS),
        .MOSI       (MOSI),
        .MISO       (MISO),
        .x_pos      (x_pos),
        .y_pos      (y_pos),
        .buttons    (buttons),
        .led_cmd    (led_cmd),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int both_cnt = 0;

    logic [7:0] exp_q[$];

    always @(negedge clk) begin
        if (frame_done) done_cnt++;
        if (frame_err) err_cnt++;
        if (frame_done && frame_err) both_cnt++;
    end

    task automatic push_frame(input logic [9:0] x, input logic [9:0] y, input logic [2:0] b);
        exp_q.push_back(x[7:0]);
        exp_q.push_back({6'b0, x[9:8]});
        exp_q.push_back(y[7:0]);
        exp_q.push_back({6'b0, y[9:8]});
        exp_q.push_back({5'b0, b});
    endtask

    function automatic logic [39:0] pop_frame();
        logic [39:0] f;
        f = '0;
        for (int k = 0; k < 5; k++) begin
            f = {f[31:0], exp_q.pop_front()};
        end
        return f;
    endfunction

    // Mode-0 master: MOSI set mid-low phase, MISO sampled just before SCLK rise.
    task automatic spi_xfer(input logic [7:0] cmd, input int nbits, input int chg_at,
                            input logic [9:0] chg_x, input int rst_at, output logic [47:0] rd);
        logic [39:0] tx;
        tx = {cmd, 32'h0};
        rd = '0;
        @(negedge clk);
        SS = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (i == chg_at) x_pos = chg_x;
            if (i == rst_at) begin
                clr_n = 1'b0;
                repeat (3) @(negedge clk);
                clr_n = 1'b1;
            end
            MOSI = (i < 40) ? tx[39-i] : 1'b0;
            repeat (4) @(negedge clk);
            rd = {rd[46:0], MISO};
            SCLK = 1'b1;
            repeat (8) @(negedge clk);
            SCLK = 1'b0;
            repeat (4) @(negedge clk);
        end
        SS = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset();
        clr_n = 1'b0; SS = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
        x_pos = 10'h2A5; y_pos = 10'h15A; buttons = 3'b101;
        repeat (3) @(negedge clk);
        checks++; if (MISO !== 1'b0) begin errors++; $display("FAIL reset_miso got %b exp 0", MISO); end
        checks++; if (led_cmd !== 2'b00) begin errors++; $display("FAIL reset_led got %b exp 00", led_cmd); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", frame_done); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", frame_err); end
        clr_n = 1'b1;
        repeat (6) @(negedge clk);
        checks++; if (MISO !== 1'b0) begin errors++; $display("FAIL idle_miso got %b exp 0", MISO); end
    endtask

    task automatic test_full_frame(input string name, input logic [7:0] cmd, input logic [1:0] exp_led);
        logic [47:0] rd;
        logic [39:0] e;
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        push_frame(x_pos, y_pos, buttons);
        spi_xfer(cmd, 40, -1, 10'h0, -1, rd);
        e = pop_frame();
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (rd[39-8*k -: 8] !== e[39-8*k -: 8]) begin
                errors++;
                $display("FAIL %s_byte%0d got %h exp %h", name, k, rd[39-8*k -: 8], e[39-8*k -: 8]);
            end
        end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL %s_done got %0d exp 1", name, done_cnt - d0); end
        checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL %s_err got %0d exp 0", name, err_cnt - e0); end
        checks++; if (led_cmd !== exp_led) begin errors++; $display("FAIL %s_led got %b exp %b", name, led_cmd, exp_led); end
    endtask

    task automatic test_short_frame();
        logic [47:0] rd;
        logic [39:0] e;
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        push_frame(x_pos, y_pos, buttons);
        spi_xfer(8'h82, 23, -1, 10'h0, -1, rd);
        e = pop_frame();
        checks++; if (rd[22:0] !== e[39:17]) begin errors++; $display("FAIL short_bits got %h exp %h", rd[22:0], e[39:17]); end
        checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL short_err got %0d exp 1", err_cnt - e0); end
        checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL short_done got %0d exp 0", done_cnt - d0); end
        checks++; if (led_cmd !== 2'b11) begin errors++; $display("FAIL short_led got %b exp 11", led_cmd); end
        test_full_frame("after_short", 8'h81, 2'b01);
    endtask

    task automatic test_snapshot();
        logic [47:0] rd;
        logic [39:0] e;
        x_pos = 10'h3FF;
        push_frame(10'h3FF, y_pos, buttons);
        spi_xfer(8'h00, 40, 8, 10'h000, -1, rd);
        e = pop_frame();
        checks++; if (rd[39:24] !== e[39:24]) begin errors++; $display("FAIL snap_x got %h exp %h", rd[39:24], e[39:24]); end
        checks++; if (rd[23:0] !== e[23:0]) begin errors++; $display("FAIL snap_rest got %h exp %h", rd[23:0], e[23:0]); end
        test_full_frame("snap_next", 8'h00, 2'b01);
    endtask

    task automatic test_reset_mid_frame();
        logic [47:0] rd;
        logic [39:0] e;
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        push_frame(x_pos, y_pos, buttons);
        spi_xfer(8'h83, 40, -1, 10'h0, 17, rd);
        e = pop_frame();
        checks++; if (rd[39:23] !== e[39:23]) begin errors++; $display("FAIL rstmid_pre got %h exp %h", rd[39:23], e[39:23]); end
        checks++; if (rd[22:0] !== 23'h0) begin errors++; $display("FAIL rstmid_post got %h exp 0", rd[22:0]); end
        checks++; if ((done_cnt - d0) + (err_cnt - e0) !== 0) begin errors++; $display("FAIL rstmid_pulses got %0d exp 0", (done_cnt - d0) + (err_cnt - e0)); end
        checks++; if (led_cmd !== 2'b00) begin errors++; $display("FAIL rstmid_led got %b exp 00", led_cmd); end
        x_pos = 10'h1C3; y_pos = 10'h2E7; buttons = 3'b010;
        test_full_frame("after_rst", 8'h82, 2'b10);
    endtask

    task automatic test_long_frame();
        logic [47:0] rd;
        logic [39:0] e;
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        push_frame(x_pos, y_pos, buttons);
        spi_xfer(8'h81, 42, -1, 10'h0, -1, rd);
        e = pop_frame();
        checks++; if (rd[41:2] !== e) begin errors++; $display("FAIL long_bits got %h exp %h", rd[41:2], e); end
        checks++; if (rd[1:0] !== 2'b00) begin errors++; $display("FAIL long_tail got %b exp 00", rd[1:0]); end
        checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL long_err got %0d exp 1", err_cnt - e0); end
        checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL long_done got %0d exp 0", done_cnt - d0); end
        checks++; if (led_cmd !== 2'b10) begin errors++; $display("FAIL long_led got %b exp 10", led_cmd); end
    endtask

    initial begin
        test_reset();
        test_full_frame("led_cmd", 8'h83, 2'b11);
        test_full_frame("non_led", 8'h40, 2'b11);
        test_short_frame();
        test_snapshot();
        test_reset_mid_frame();
        test_long_frame();
        checks++; if (both_cnt !== 0) begin errors++; $display("FAIL pulse_overlap got %0d exp 0", both_cnt); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
